// File: rtl/bus_io_port_pkg.sv
// Shared definitions for the bus_io_port memory-mapped I/O responder.
// Holds the STATUS register bit positions and a helper that packs the
// STATUS byte so the top level and anyone reading it agree on the layout.
package bus_io_port_pkg;

  localparam int ST_RX_NE    = 0;  // RX FIFO holds at least one byte
  localparam int ST_TX_FULL  = 1;  // TX FIFO cannot accept another byte
  localparam int ST_RX_OVF   = 2;  // sticky: an RX byte was dropped
  localparam int ST_TX_EMPTY = 3;  // TX FIFO fully drained

  function automatic logic [7:0] pack_status(input logic rx_ne,
                                             input logic tx_full,
                                             input logic rx_ovf,
                                             input logic tx_empty);
    logic [7:0] s;
    s              = 8'h00;
    s[ST_RX_NE]    = rx_ne;
    s[ST_TX_FULL]  = tx_full;
    s[ST_RX_OVF]   = rx_ovf;
    s[ST_TX_EMPTY] = tx_empty;
    return s;
  endfunction

endpackage

// File: rtl/bus_io_port_sync_fifo.sv
// sync_fifo: single-clock FIFO of 2**DEPTH_LOG2 entries.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   push, push_data     write request; accepted only when not full
//   pop                 read request; accepted only when not empty
//   head                oldest entry (meaningless while empty)
//   full, empty         occupancy flags, derived from the current pointers
// Push and pop in the same cycle are judged against the flags before the
// edge, so a push on a full FIFO is rejected even when a pop happens too.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic                push_ok;
  logic                pop_ok;

  always_comb begin
    full     = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
               (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    head     = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bus_io_port.sv
// bus_io_port: memory-mapped I/O slave on the CPU's 8-bit shared data bus.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   addr_bus[15:0]        CPU address; DATA at BASE_ADDR, STATUS at BASE_ADDR+1
//   bus[7:0]              shared data bus, driven only during a selected read
//   bus_rd_n, bus_wr_n    active-low strobes, one cycle per transaction
//   tx_data/tx_valid/tx_ready   outgoing stream fed by CPU writes to DATA
//   rx_data/rx_valid/rx_ready   incoming stream popped by CPU reads of DATA
// Stream handshake: a byte moves on a rising edge where valid and ready are
// both high; valid never depends on ready, and the data held under valid
// stays stable until the transfer completes.
module bus_io_port
  import bus_io_port_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_bus,
  inout  wire  [7:0]  bus,
  input  logic        bus_rd_n,
  input  logic        bus_wr_n,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;

  logic       sel_data;
  logic       sel_stat;
  logic       rd_act;
  logic       wr_act;
  logic       tx_full, tx_empty;
  logic       rx_full, rx_empty;
  logic [7:0] rx_head;
  logic [7:0] status;
  logic [7:0] rd_data;
  logic       drive_en;
  logic       ovf_q, ovf_d;

  always_comb begin
    sel_data = (addr_bus == BASE_ADDR);
    sel_stat = (addr_bus == STAT_ADDR);
    rd_act   = !bus_rd_n;
    // A write colliding with a read is dropped; the read still proceeds.
    wr_act   = !bus_wr_n && bus_rd_n;
    tx_valid = !tx_empty;
    rx_ready = !rx_full;
    status   = pack_status(!rx_empty, tx_full, ovf_q, tx_empty);
    rd_data  = sel_data ? (rx_empty ? 8'h00 : rx_head) : status;
    drive_en = rd_act && (sel_data || sel_stat);
  end

  assign bus = drive_en ? rd_data : 8'hzz;

  // Overflow is sticky; a drop in the same cycle as a CPU clear wins.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_act && sel_stat && bus[ST_RX_OVF]) ovf_d = 1'b0;
    if (rx_valid && rx_full)                 ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_act && sel_data),
    .push_data (bus),
    .pop       (tx_ready),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rd_act && sel_data),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Both strobes low at once is a CPU protocol violation.
  strobe_conflict_a : assert property (@(posedge clk) disable iff (reset)
    !(!bus_rd_n && !bus_wr_n));

endmodule

// File: tb/tb_bus_io_port.sv
module tb_bus_io_port;

  localparam logic [15:0] A_DATA = 16'hFF00;
  localparam logic [15:0] A_STAT = 16'hFF01;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr_bus;
  wire  [7:0]  bus;
  logic        bus_rd_n, bus_wr_n;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;

  logic        tb_en;
  logic [7:0]  tb_drv;

  // Bench drives the bus only for CPU writes; an undriven bus floats high.
  assign bus = tb_en ? tb_drv : 8'hzz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (bus[gi]);
  end

  bus_io_port dut (
    .clk      (clk),
    .reset    (reset),
    .addr_bus (addr_bus),
    .bus      (bus),
    .bus_rd_n (bus_rd_n),
    .bus_wr_n (bus_wr_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state: expected FIFO contents and overflow flag
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       ovf_m;
  int         vectors     = 0;
  int         miscompares = 0;

  function automatic logic [7:0] status_m();
    return {4'b0000, tx_q.size() == 0, ovf_m, tx_q.size() == 4, rx_q.size() != 0};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    addr_bus = a;
    tb_drv   = d;
    tb_en    = 1'b1;
    bus_wr_n = 1'b0;
    if (a == A_DATA && tx_q.size() < 4) tx_q.push_back(d);
    if (a == A_STAT && d[2]) ovf_m = 1'b0;
    step();
    bus_wr_n = 1'b1;
    tb_en    = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [15:0] a);
    logic [7:0] exp;
    addr_bus = a;
    bus_rd_n = 1'b0;
    @(negedge clk);
    if (a == A_DATA) exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
    else             exp = status_m();
    check(tag, bus, exp);
    step();
    bus_rd_n = 1'b1;
  endtask

  task automatic drain_tx(input int n);
    tx_ready = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check("tx_valid_drain", {7'b0, tx_valid}, 8'd1);
      if (tx_q.size() != 0) check("tx_data_drain", tx_data, tx_q.pop_front());
      step();
    end
    tx_ready = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    @(negedge clk);
    check("rx_ready", {7'b0, rx_ready}, {7'b0, rx_q.size() < 4});
    if (rx_q.size() < 4) rx_q.push_back(d);
    else                 ovf_m = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    addr_bus = 16'h0000;
    bus_rd_n = 1'b1;
    bus_wr_n = 1'b1;
    tb_en    = 1'b0;
    tb_drv   = 8'h00;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    ovf_m    = 1'b0;
    repeat (2) step();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_tx_valid", {7'b0, tx_valid}, 8'd0);
    check("rst_rx_ready", {7'b0, rx_ready}, 8'd1);
    check("rst_bus_hiz", bus, 8'hFF);
    step();
    cpu_read("rst_status", A_STAT);
    check("rst_status_const", status_m(), 8'h08);

    // Two writes, then drain
    cpu_write(A_DATA, 8'hA5);
    cpu_write(A_DATA, 8'h3C);
    @(negedge clk);
    check("tx_valid_after_wr", {7'b0, tx_valid}, 8'd1);
    check("tx_head_hold", tx_data, 8'hA5);
    step();
    drain_tx(2);
    @(negedge clk);
    check("tx_valid_drained", {7'b0, tx_valid}, 8'd0);
    step();
    cpu_read("status_tx_empty", A_STAT);

    // Fill TX past full
    for (int i = 1; i <= 4; i++) cpu_write(A_DATA, i[7:0]);
    cpu_read("status_tx_full", A_STAT);
    cpu_write(A_DATA, 8'h05);
    drain_tx(4);
    @(negedge clk);
    check("tx_valid_after_4", {7'b0, tx_valid}, 8'd0);
    step();

    // TX full with concurrent pop and push: pop wins, push rejected
    for (int i = 0; i < 4; i++) cpu_write(A_DATA, 8'h51 + i[7:0]);
    tx_ready = 1'b1;
    addr_bus = A_DATA;
    tb_drv   = 8'h55;
    tb_en    = 1'b1;
    bus_wr_n = 1'b0;
    @(negedge clk);
    check("tx_full_pop_head", tx_data, tx_q.pop_front());
    step();
    bus_wr_n = 1'b1;
    tb_en    = 1'b0;
    tx_ready = 1'b0;
    drain_tx(3);
    @(negedge clk);
    check("tx_valid_full_pp", {7'b0, tx_valid}, 8'd0);
    step();

    // RX fill with overflow
    for (int i = 0; i < 5; i++) rx_push(8'h11 + i[7:0]);
    cpu_read("status_rx_ovf", A_STAT);
    for (int i = 0; i < 4; i++) cpu_read("rx_data_read", A_DATA);
    cpu_read("rx_empty_read", A_DATA);
    cpu_read("status_after_empty", A_STAT);

    // Overflow clear, then clear colliding with a new overflow
    cpu_write(A_STAT, 8'h04);
    cpu_read("status_ovf_clr", A_STAT);
    for (int i = 0; i < 4; i++) rx_push(8'h21 + i[7:0]);
    rx_valid = 1'b1;
    rx_data  = 8'h25;
    addr_bus = A_STAT;
    tb_drv   = 8'h04;
    tb_en    = 1'b1;
    bus_wr_n = 1'b0;
    ovf_m    = 1'b1;
    step();
    rx_valid = 1'b0;
    bus_wr_n = 1'b1;
    tb_en    = 1'b0;
    cpu_read("status_ovf_set_wins", A_STAT);

    // Leave 2 entries, then read and push in one cycle
    cpu_read("rx_pop_21", A_DATA);
    cpu_read("rx_pop_22", A_DATA);
    rx_valid = 1'b1;
    rx_data  = 8'h31;
    addr_bus = A_DATA;
    bus_rd_n = 1'b0;
    @(negedge clk);
    check("rx_rdpush_bus", bus, rx_q.pop_front());
    check("rx_rdpush_ready", {7'b0, rx_ready}, 8'd1);
    rx_q.push_back(8'h31);
    step();
    rx_valid = 1'b0;
    bus_rd_n = 1'b1;
    cpu_read("rx_order_1", A_DATA);
    cpu_read("rx_order_2", A_DATA);
    cpu_read("status_rx_drained", A_STAT);

    // Reset mid-stream
    cpu_write(A_DATA, 8'hAA);
    cpu_write(A_DATA, 8'hBB);
    rx_push(8'h41);
    reset    = 1'b1;
    addr_bus = A_DATA;
    tb_drv   = 8'hCC;
    tb_en    = 1'b1;
    bus_wr_n = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h42;
    step();
    reset    = 1'b0;
    bus_wr_n = 1'b1;
    tb_en    = 1'b0;
    rx_valid = 1'b0;
    tx_q.delete();
    rx_q.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    check("mid_rst_tx_valid", {7'b0, tx_valid}, 8'd0);
    check("mid_rst_rx_ready", {7'b0, rx_ready}, 8'd1);
    step();
    cpu_read("mid_rst_status", A_STAT);
    cpu_read("mid_rst_data", A_DATA);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
